// File: rtl/mul_div_unit.sv
// mul_div_unit: fixed 32-cycle radix-2 multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU); ports iCLK, iRST, iStart, iFunct3, iA, iB -> oResult, oZero, oBusy, oDone
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic [XLEN-1:0] oResult,
  output logic            oZero,
  output logic            oBusy,
  output logic            oDone
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [2:0] f3;
  logic [31:0] m, ma_in, mb_in, q, r, res;
  logic [63:0] p, p_nx, prod;
  logic [32:0] sum, sh, dif;
  logic neg_q, neg_r, bz, sa_in, sb_in;
  assign sa_in = iA[31] & (iFunct3 == 3'b001 || iFunct3 == 3'b010 || iFunct3 == 3'b100 || iFunct3 == 3'b110);
  assign sb_in = iB[31] & (iFunct3 == 3'b001 || iFunct3 == 3'b100 || iFunct3 == 3'b110);
  assign ma_in = sa_in ? -iA : iA;
  assign mb_in = sb_in ? -iB : iB;
  // Multiply: shift-add of magnitudes, product accumulates in p[63:32] while the multiplier shifts out of p[31:0].
  // Divide: restoring division, remainder in p[63:32], dividend shifts out / quotient shifts in at p[31:0].
  assign sum = {1'b0, p[63:32]} + {1'b0, p[0] ? m : 32'd0};
  assign sh = {p[63:32], p[31]};
  assign dif = sh - {1'b0, m};
  assign p_nx = f3[2] ? (dif[32] ? {sh[31:0], p[30:0], 1'b0} : {dif[31:0], p[30:0], 1'b1})
                      : {sum, p[31:1]};
  assign prod = neg_q ? -p_nx : p_nx;
  assign q = neg_q ? -p_nx[31:0] : p_nx[31:0];
  assign r = neg_r ? -p_nx[63:32] : p_nx[63:32];
  // A zero divisor naturally leaves remainder = |dividend|; only the signed quotient needs forcing to all ones.
  assign res = f3[2] ? (f3[1] ? r : (bz ? 32'hFFFF_FFFF : q))
                     : (f3[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
  assign oZero = oResult == '0;
  assign oBusy = state == CALC;
  assign oDone = state == DONE;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      cnt <= '0;
      oResult <= '0;
      f3 <= '0;
      m <= '0;
      p <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz <= 1'b0;
    end else if (state != CALC && iStart) begin
      state <= CALC;
      cnt <= '0;
      f3 <= iFunct3;
      m <= iFunct3[2] ? mb_in : ma_in;
      p <= {32'd0, iFunct3[2] ? ma_in : mb_in};
      neg_q <= sa_in ^ sb_in;
      neg_r <= sa_in;
      bz <= iB == '0;
    end else if (state == CALC) begin
      p <= p_nx;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        state <= DONE;
        oResult <= res;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven self-checking bench for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst, start, zero, busy, done;
  logic [2:0] f3;
  logic [31:0] a, b, res;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [2:0] fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    string name;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  mul_div_unit #(.XLEN(32)) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iFunct3(f3), .iA(a), .iB(b),
    .oResult(res), .oZero(zero), .oBusy(busy), .oDone(done)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input string name);
    int cyc, nb;
    @(negedge clk);
    start = 1'b1; f3 = fn; a = x; b = y;
    @(negedge clk);
    start = 1'b0; f3 = ~fn; a = $urandom; b = $urandom;
    cyc = 0; nb = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'd32);
    check({name, " busy_cycles"}, 32'(nb), 32'd32);
    check({name, " result"}, res, e);
    check({name, " zero"}, {31'd0, zero}, {31'd0, e == 32'd0});
    @(negedge clk);
    check({name, " done_single"}, {31'd0, done}, 32'd0);
    check({name, " result_hold"}, res, e);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int nd, t[$];
    vecs.push_back('{3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3"});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff"});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1_m1"});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulhsu_m1_2"});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "div_m7_2"});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, "rem_m7_2"});
    vecs.push_back('{3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, "divu_big_2"});
    vecs.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_5_0"});
    vecs.push_back('{3'b111, 32'd5, 32'd0, 32'h00000005, "remu_5_0"});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_m7_0"});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_m7_0"});
    vecs.push_back('{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2"});
    vecs.push_back('{3'b110, 32'd7, 32'hFFFFFFFE, 32'h00000001, "rem_7_m2"});
    vecs.push_back('{3'b100, 32'd100, 32'd7, 32'd14, "div_100_7"});
    vecs.push_back('{3'b111, 32'hFFFFFFF9, 32'd2, 32'd1, "remu_big_2"});
    vecs.push_back('{3'b000, 32'h12345678, 32'h10, 32'h23456780, "mul_shift"});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min"});
    vecs.push_back('{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mulhsu_min_max"});
    vecs.push_back('{3'b011, 32'h80000000, 32'd4, 32'd2, "mulhu_min_4"});
    rst = 1'b1; start = 1'b0; f3 = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", res, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd1);
    rst = 1'b0;
    foreach (vecs[i]) run_op(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].name);
    @(negedge clk);
    start = 1'b1; f3 = 3'b000; a = 32'd7; b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; f3 = 3'b100; a = 32'd99; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("ignored_start done_count", 32'(nd), 32'd1);
    check("ignored_start result", res, 32'hFFFFFFEB);
    check("ignored_start idle", {31'd0, busy}, 32'd0);
    start = 1'b1; f3 = 3'b101; a = 32'hFFFFFFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort result", res, 32'd0);
    check("abort zero", {31'd0, zero}, 32'd1);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("abort no_done", 32'(nd), 32'd0);
    run_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "after_abort");
    @(negedge clk);
    start = 1'b1; f3 = 3'b000; a = 32'd3; b = 32'd5;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(i);
        check("held_start result", res, 32'd15);
      end
    end
    start = 1'b0;
    check("held_start pulses", 32'(t.size()), 32'd3);
    if (t.size() >= 3) begin
      check("held_start period1", 32'(t[1] - t[0]), 32'd33);
      check("held_start period2", 32'(t[2] - t[1]), 32'd33);
    end
    repeat (40) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
